// File: rtl/logic_capture_pkg.sv
// logic_capture_pkg
//   Shared definitions for the logic analyser capture engine: capture state
//   encoding, packet width helper and the post-trigger window clamp.
package logic_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A packet is {stamp, sample}.
  function automatic int packet_width(input int sample_w, input int ts_w);
    return sample_w + ts_w;
  endfunction

  // Limit post so that pre + trigger + post never exceeds the buffer depth,
  // otherwise the oldest pre-trigger packets would be overwritten.
  function automatic int unsigned clamp_post(input int unsigned pre,
                                             input int unsigned post,
                                             input int unsigned addr_w);
    int unsigned limit;
    limit = (32'd1 << addr_w) - 32'd1 - pre;
    return (post > limit) ? limit : post;
  endfunction

endpackage

// File: rtl/logic_capture_core_trigger.sv
// capture_trigger
//   Combinational trigger evaluation on the synchronised sample stream.
//   Ports:
//     cur, prev            current and previous synchronised samples
//     pattern, care_mask   pattern match value and compare mask (1 = compared)
//     pattern_en, edge_en  trigger source enables
//     edge_channel         channel watched for an edge
//     edge_rising          1 = rising edge, 0 = falling edge
//     hit                  trigger condition for this cycle
module capture_trigger
  import logic_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  localparam int CH_W        = $clog2(SAMPLE_WIDTH)
) (
  input  logic [SAMPLE_WIDTH-1:0] cur,
  input  logic [SAMPLE_WIDTH-1:0] prev,
  input  logic [SAMPLE_WIDTH-1:0] pattern,
  input  logic [SAMPLE_WIDTH-1:0] care_mask,
  input  logic                    pattern_en,
  input  logic                    edge_en,
  input  logic [CH_W-1:0]         edge_channel,
  input  logic                    edge_rising,
  output logic                    hit
);

  logic pattern_hit;
  logic edge_hit;

  assign pattern_hit = (((cur ^ pattern) & care_mask) == '0);
  assign edge_hit    = edge_rising ? (!prev[edge_channel] &&  cur[edge_channel])
                                   : ( prev[edge_channel] && !cur[edge_channel]);

  // With no source enabled the trigger is unconditional, so capture
  // triggers on the first armed cycle.
  always_comb begin
    hit = 1'b1;
    case ({pattern_en, edge_en})
      2'b11:   hit = pattern_hit && edge_hit;
      2'b10:   hit = pattern_hit;
      2'b01:   hit = edge_hit;
      default: hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_capture_core.sv
// logic_capture_core
//   Capture engine: synchronises the probe bus, evaluates triggers and stores
//   masked samples in a circular buffer with a pre/post-trigger window.
//   Optional run-length compression is enabled by defining
//   LOGIC_CAPTURE_RLE_EN.
//   Ports:
//     clk, reset              clock, synchronous active-high reset
//     sample_async            asynchronous probe inputs
//     start, abort            single-cycle arm / abort requests
//     active_channels         store mask (inactive channels stored as 0)
//     pattern, care_mask      pattern trigger value and compare mask
//     pattern_en, edge_en     trigger source enables
//     edge_channel, edge_rising  edge trigger channel and polarity
//     pre_count, post_count   window sizes in packets
//     state                   IDLE=0 PRE=1 ARMED=2 POST=3 DONE=4
//     trig_addr, first_addr   trigger packet and oldest valid packet addresses
//     rd_addr, rd_data        readback port, one-cycle latency
module logic_capture_core
  import logic_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int ADDR_W        = 10,
  parameter int TS_WIDTH      = 8,
  localparam int PACKET_WIDTH = packet_width(SAMPLE_WIDTH, TS_WIDTH),
  localparam int CH_W         = $clog2(SAMPLE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_async,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SAMPLE_WIDTH-1:0] active_channels,
  input  logic [SAMPLE_WIDTH-1:0] pattern,
  input  logic [SAMPLE_WIDTH-1:0] care_mask,
  input  logic                    pattern_en,
  input  logic                    edge_en,
  input  logic [CH_W-1:0]         edge_channel,
  input  logic                    edge_rising,
  input  logic [ADDR_W-1:0]       pre_count,
  input  logic [ADDR_W-1:0]       post_count,
  output logic [2:0]              state,
  output logic [ADDR_W-1:0]       trig_addr,
  output logic [ADDR_W-1:0]       first_addr,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [PACKET_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [SAMPLE_WIDTH-1:0] sync_p0, sync_p1, cur_p2, prev_p3;

  state_t                  st;
  logic [ADDR_W-1:0]       wr_addr, count;
  logic [SAMPLE_WIDTH-1:0] act_lat, pat_lat, care_lat;
  logic                    pen_lat, een_lat, erise_lat;
  logic [CH_W-1:0]         ech_lat;
  logic [ADDR_W-1:0]       pre_lat, post_lat;

  logic                    hit, trig, capturing, accept_start, wr_cond, wr_en;
  logic [SAMPLE_WIDTH-1:0] masked;
  logic [TS_WIDTH-1:0]     stamp;

  logic [PACKET_WIDTH-1:0] mem [2**ADDR_W];

  // Stage p0/p1: two-flop synchroniser; p2: cur; p3: prev. Free-running.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      cur_p2  <= '0;
      prev_p3 <= '0;
    end else begin
      sync_p0 <= sample_async;
      sync_p1 <= sync_p0;
      cur_p2  <= sync_p1;
      prev_p3 <= cur_p2;
    end
  end

  capture_trigger #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_trigger (
    .cur          (cur_p2),
    .prev         (prev_p3),
    .pattern      (pat_lat),
    .care_mask    (care_lat),
    .pattern_en   (pen_lat),
    .edge_en      (een_lat),
    .edge_channel (ech_lat),
    .edge_rising  (erise_lat),
    .hit          (hit)
  );

  assign masked       = cur_p2 & act_lat;
  assign trig         = (st == ST_ARMED) && hit;
  assign capturing    = (st == ST_PRE) || (st == ST_ARMED) || (st == ST_POST);
  assign accept_start = ((st == ST_IDLE) || (st == ST_DONE)) && start && !abort;
  assign wr_en        = capturing && !abort && !reset && wr_cond;

`ifdef LOGIC_CAPTURE_RLE_EN
  logic [TS_WIDTH-1:0]     since;
  logic [SAMPLE_WIDTH-1:0] last_sample;
  logic                    first_pending;

  // A packet is emitted on change, on stamp saturation, for the first packet
  // of a capture and always for the trigger sample.
  assign wr_cond = first_pending || (masked != last_sample) || (since == '1) || trig;
  assign stamp   = first_pending ? TS_WIDTH'(1) : since;

  always_ff @(posedge clk) begin
    if (reset) begin
      since         <= TS_WIDTH'(1);
      first_pending <= 1'b0;
    end else if (accept_start) begin
      since         <= TS_WIDTH'(1);
      first_pending <= 1'b1;
    end else if (wr_en) begin
      since         <= TS_WIDTH'(1);
      first_pending <= 1'b0;
    end else if (since != '1) begin
      since <= since + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) last_sample <= masked;
  end
`else
  assign wr_cond = 1'b1;
  assign stamp   = TS_WIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {stamp, masked};
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

  // Configuration snapshot, taken only on an accepted start.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      act_lat   <= active_channels;
      pat_lat   <= pattern;
      care_lat  <= care_mask;
      pen_lat   <= pattern_en;
      een_lat   <= edge_en;
      ech_lat   <= edge_channel;
      erise_lat <= edge_rising;
      pre_lat   <= pre_count;
      post_lat  <= ADDR_W'(clamp_post(32'(pre_count), 32'(post_count), ADDR_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      wr_addr    <= '0;
      count      <= '0;
      trig_addr  <= '0;
      first_addr <= '0;
    end else begin
      if (wr_en) wr_addr <= wr_addr + ADDR_ONE;
      case (st)
        ST_IDLE, ST_DONE: begin
          if (accept_start) begin
            wr_addr <= '0;
            count   <= '0;
            st      <= (pre_count == '0) ? ST_ARMED : ST_PRE;
          end
        end
        ST_PRE: begin
          if (abort) begin
            st <= ST_IDLE;
          end else if (wr_en) begin
            if (count + ADDR_ONE == pre_lat) begin
              count <= '0;
              st    <= ST_ARMED;
            end else begin
              count <= count + ADDR_ONE;
            end
          end
        end
        ST_ARMED: begin
          if (abort) begin
            st <= ST_IDLE;
          end else if (trig) begin
            trig_addr <= wr_addr;
            count     <= '0;
            if (post_lat == '0) begin
              first_addr <= wr_addr - pre_lat;
              st         <= ST_DONE;
            end else begin
              st <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (abort) begin
            st <= ST_IDLE;
          end else if (wr_en) begin
            if (count + ADDR_ONE == post_lat) begin
              first_addr <= trig_addr - pre_lat;
              st         <= ST_DONE;
            end else begin
              count <= count + ADDR_ONE;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_logic_capture_core.sv
// tb_logic_capture_core
//   Directed bench for logic_capture_core (default build, compression off)
//   with a 16-entry buffer so that wrap-around and window clamping are
//   reachable in a few dozen cycles.
module tb_logic_capture_core;

  localparam int SW = 16;
  localparam int AW = 4;
  localparam int TW = 8;
  localparam int PW = SW + TW;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sample_async;
  logic          start, abort;
  logic [SW-1:0] active_channels, pattern, care_mask;
  logic          pattern_en, edge_en, edge_rising;
  logic [3:0]    edge_channel;
  logic [AW-1:0] pre_count, post_count, trig_addr, first_addr, rd_addr;
  logic [2:0]    state;
  logic [PW-1:0] rd_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  logic_capture_core #(.SAMPLE_WIDTH(SW), .ADDR_W(AW), .TS_WIDTH(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_async    (sample_async),
    .start           (start),
    .abort           (abort),
    .active_channels (active_channels),
    .pattern         (pattern),
    .care_mask       (care_mask),
    .pattern_en      (pattern_en),
    .edge_en         (edge_en),
    .edge_channel    (edge_channel),
    .edge_rising     (edge_rising),
    .pre_count       (pre_count),
    .post_count      (post_count),
    .state           (state),
    .trig_addr       (trig_addr),
    .first_addr      (first_addr),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; sample_async = '0;
    active_channels = '1; pattern = '0; care_mask = '0;
    pattern_en = 1'b0; edge_en = 1'b0; edge_channel = '0; edge_rising = 1'b1;
    pre_count = '0; post_count = '0; rd_addr = '0;
    repeat (3) step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (trig_addr !== 4'd0) begin fails++; $display("FAIL reset_trig_addr: got %0h expected 0", trig_addr); end
    checks++; if (first_addr !== 4'd0) begin fails++; $display("FAIL reset_first_addr: got %0h expected 0", first_addr); end
    checks++; if (rd_data !== 24'd0) begin fails++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    reset = 1'b0;
    step();
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL post_reset_state: got %0d expected 0", state); end
  endtask

  // Ramp 0x9B.. ; start at i=2; PRE writes v0..v3, trigger write carries 0xA5.
  task automatic test_pattern();
    logic [2:0]    exp_st;
    logic [PW-1:0] exp_pk;
    pattern_en = 1'b1; edge_en = 1'b0; pattern = 16'h00A5; care_mask = 16'hFFFF;
    active_channels = 16'hFFFF; pre_count = 4'd4; post_count = 4'd3;
    for (int i = 0; i < 20; i++) begin
      if (i >= 3) begin
        exp_st = (i < 7) ? 3'd1 : (i < 14) ? 3'd2 : (i < 17) ? 3'd3 : 3'd4;
        checks++;
        if (state !== exp_st) begin fails++; $display("FAIL pattern_state[%0d]: got %0d expected %0d", i, state, exp_st); end
      end
      sample_async = 16'(32'h009B + i);
      start = (i == 2);
      step();
    end
    start = 1'b0;
    checks++; if (trig_addr !== 4'd10) begin fails++; $display("FAIL pattern_trig_addr: got %0h expected a", trig_addr); end
    checks++; if (first_addr !== 4'd6) begin fails++; $display("FAIL pattern_first_addr: got %0h expected 6", first_addr); end
    for (int k = 0; k < 8; k++) begin
      rd_addr = 4'(6 + k);
      step();
      exp_pk = {8'd1, 16'(32'h00A1 + k)};
      checks++;
      if (rd_data !== exp_pk) begin fails++; $display("FAIL pattern_readback[%0d]: got %0h expected %0h", k, rd_data, exp_pk); end
    end
  endtask

  // Bit 3 rises (v4) then falls (v6); only the fall triggers, at address 8.
  task automatic test_edge();
    logic [2:0] exp_st;
    pattern_en = 1'b0; edge_en = 1'b1; edge_channel = 4'd3; edge_rising = 1'b0;
    active_channels = 16'hFFFF; pre_count = 4'd0; post_count = 4'd0;
    for (int i = -4; i <= 12; i++) begin
      if (i >= 1) begin
        exp_st = (i < 10) ? 3'd2 : 3'd4;
        checks++;
        if (state !== exp_st) begin fails++; $display("FAIL edge_state[%0d]: got %0d expected %0d", i, state, exp_st); end
      end
      sample_async = (i == 4 || i == 5) ? 16'h0008 : 16'h0000;
      start = (i == 0);
      step();
    end
    start = 1'b0;
    checks++; if (trig_addr !== 4'd8) begin fails++; $display("FAIL edge_trig_addr: got %0h expected 8", trig_addr); end
    checks++; if (first_addr !== 4'd8) begin fails++; $display("FAIL edge_first_addr: got %0h expected 8", first_addr); end
    rd_addr = 4'd7; step();
    checks++; if (rd_data !== {8'd1, 16'h0008}) begin fails++; $display("FAIL edge_pre_sample: got %0h expected 10008", rd_data); end
    rd_addr = 4'd8; step();
    checks++; if (rd_data !== {8'd1, 16'h0000}) begin fails++; $display("FAIL edge_trig_sample: got %0h expected 10000", rd_data); end
  endtask

  // No source enabled, pre=0, post=5; channel mask 0x0FFF applied on store.
  task automatic test_no_source();
    logic [2:0] exp_st;
    pattern_en = 1'b0; edge_en = 1'b0; active_channels = 16'h0FFF;
    pre_count = 4'd0; post_count = 4'd5;
    for (int i = -4; i <= 10; i++) begin
      if (i >= 1) begin
        exp_st = (i == 1) ? 3'd2 : (i < 7) ? 3'd3 : 3'd4;
        checks++;
        if (state !== exp_st) begin fails++; $display("FAIL nosrc_state[%0d]: got %0d expected %0d", i, state, exp_st); end
      end
      sample_async = 16'(32'h1000 + i);
      start = (i == 0);
      step();
    end
    start = 1'b0;
    checks++; if (trig_addr !== 4'd0) begin fails++; $display("FAIL nosrc_trig_addr: got %0h expected 0", trig_addr); end
    checks++; if (first_addr !== 4'd0) begin fails++; $display("FAIL nosrc_first_addr: got %0h expected 0", first_addr); end
    rd_addr = 4'd0; step();
    checks++; if (rd_data !== {8'd1, 16'h0FFE}) begin fails++; $display("FAIL nosrc_trig_sample: got %0h expected 10ffe", rd_data); end
    rd_addr = 4'd5; step();
    checks++; if (rd_data !== {8'd1, 16'h0003}) begin fails++; $display("FAIL nosrc_last_sample: got %0h expected 10003", rd_data); end
  endtask

  // pre=10, post=10 on a 16-deep buffer: post clamps to 5, trigger after wrap.
  task automatic test_clamp_wrap();
    logic [2:0] exp_st;
    pattern_en = 1'b1; edge_en = 1'b0; pattern = 16'h2011; care_mask = 16'hFFFF;
    active_channels = 16'hFFFF; pre_count = 4'd10; post_count = 4'd10;
    for (int i = -4; i <= 28; i++) begin
      if (i >= 1) begin
        exp_st = (i < 11) ? 3'd1 : (i < 21) ? 3'd2 : (i < 26) ? 3'd3 : 3'd4;
        checks++;
        if (state !== exp_st) begin fails++; $display("FAIL clamp_state[%0d]: got %0d expected %0d", i, state, exp_st); end
      end
      sample_async = 16'(32'h2000 + i);
      start = (i == 0);
      step();
    end
    start = 1'b0;
    checks++; if (trig_addr !== 4'd3) begin fails++; $display("FAIL clamp_trig_addr: got %0h expected 3", trig_addr); end
    checks++; if (first_addr !== 4'd9) begin fails++; $display("FAIL clamp_first_addr: got %0h expected 9", first_addr); end
    rd_addr = 4'd9; step();
    checks++; if (rd_data !== {8'd1, 16'h2007}) begin fails++; $display("FAIL clamp_oldest: got %0h expected 12007", rd_data); end
    rd_addr = 4'd2; step();
    checks++; if (rd_data !== {8'd1, 16'h2010}) begin fails++; $display("FAIL clamp_wrapped_pre: got %0h expected 12010", rd_data); end
    rd_addr = 4'd3; step();
    checks++; if (rd_data !== {8'd1, 16'h2011}) begin fails++; $display("FAIL clamp_trig_sample: got %0h expected 12011", rd_data); end
    rd_addr = 4'd8; step();
    checks++; if (rd_data !== {8'd1, 16'h2016}) begin fails++; $display("FAIL clamp_last_post: got %0h expected 12016", rd_data); end
  endtask

  // Abort in POST (with a simultaneous start), start+abort in IDLE, and a
  // reset while armed.
  task automatic test_abort();
    logic [2:0] exp_st;
    pattern_en = 1'b0; edge_en = 1'b0; active_channels = 16'hFFFF;
    pre_count = 4'd0; post_count = 4'd5;
    for (int i = 0; i <= 10; i++) begin
      if (i >= 1 && i <= 9) begin
        exp_st = (i == 1 || i == 8) ? 3'd2 : (i == 2 || i == 3) ? 3'd3 : 3'd0;
        checks++;
        if (state !== exp_st) begin fails++; $display("FAIL abort_state[%0d]: got %0d expected %0d", i, state, exp_st); end
      end
      if (i == 7) begin
        checks++;
        if (first_addr !== 4'd9) begin fails++; $display("FAIL abort_first_addr_hold: got %0h expected 9", first_addr); end
      end
      if (i == 9) begin
        checks++;
        if (first_addr !== 4'd0) begin fails++; $display("FAIL abort_first_addr_reset: got %0h expected 0", first_addr); end
      end
      sample_async = 16'(32'h3000 + i);
      abort = (i == 3 || i == 5);
      start = (i == 0 || i == 3 || i == 5 || i == 7);
      reset = (i == 8);
      step();
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_edge();
    test_no_source();
    test_clamp_wrap();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
